// File: rtl/tcm_ber_meter_pkg.sv
// Shared TCM types for the BER meter: PRBS definition, window FSM states,
// and the word popcount helper.
package tcm_ber_meter_pkg;

  localparam int unsigned PRBS_DEG = 23;
  localparam int unsigned PRBS_TAP = 18;
  localparam logic [PRBS_DEG-1:0] PRBS_SEED_DEF = 23'h7FFFFF;

  // Every code rate compares at least this many bits per word
  localparam int unsigned BASE_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_SOP,
    ST_IN_PKT,
    ST_DONE
  } ber_state_t;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      c = c + 5'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/tcm_ber_meter_prbs.sv
// Word-parallel PRBS x^23+x^18+1: oword carries the next pDAT_W sequence bits,
// first bit in the LSB.
module tcm_prbs_word
  import tcm_ber_meter_pkg::*;
#(
  parameter int unsigned         pDAT_W = 11,
  parameter logic [PRBS_DEG-1:0] pSEED  = PRBS_SEED_DEF
) (
  input  logic              iclk,
  input  logic              ireset,
  input  logic              iclkena,
  input  logic              ireload,
  input  logic              iadvance,
  output logic [pDAT_W-1:0] oword
);

  logic [PRBS_DEG-1:0] lfsr_q, lfsr_d;
  logic [PRBS_DEG-1:0] base, walk;
  logic                nb;

  // A reload takes effect on the same word, so the seed feeds the word logic directly
  always_comb begin
    base  = ireload ? pSEED : lfsr_q;
    walk  = base;
    oword = '0;
    nb    = 1'b0;
    for (int unsigned i = 0; i < pDAT_W; i++) begin
      nb       = walk[PRBS_DEG-1] ^ walk[PRBS_TAP-1];
      oword[i] = nb;
      walk     = {walk[PRBS_DEG-2:0], nb};
    end
    lfsr_d = iadvance ? walk : base;
  end

  always_ff @(posedge iclk) begin
    if (ireset) begin
      lfsr_q <= pSEED;
    end else if (iclkena) begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/tcm_ber_meter.sv
// Bit/frame error meter for a TCM decoder output: compares decoded words to the
// reference PRBS over a window of packets with saturating counters.
module tcm_ber_meter
  import tcm_ber_meter_pkg::*;
#(
  parameter int unsigned         pDAT_W = 11,
  parameter int unsigned         pCNT_W = 40,
  parameter int unsigned         pPKT_W = 16,
  parameter logic [PRBS_DEG-1:0] pSEED  = PRBS_SEED_DEF
) (
  input  logic              iclk,
  input  logic              ireset,
  input  logic              iclkena,
  input  logic [1:0]        icode,
  input  logic              istart,
  input  logic [pPKT_W-1:0] inpkt,
  input  logic              isop,
  input  logic              ival,
  input  logic              ieop,
  input  logic [pDAT_W-1:0] idat,
  output logic              obusy,
  output logic              odone,
  output logic [pCNT_W-1:0] obit_cnt,
  output logic [pCNT_W-1:0] obiterr,
  output logic [pPKT_W-1:0] opkt_cnt,
  output logic [pPKT_W-1:0] ofrm_err,
  output logic [pPKT_W-1:0] opkt_lost,
  output logic              osat
);

  ber_state_t        st_q, st_d;
  logic [1:0]        code_q;
  logic [pPKT_W-1:0] npkt_q, seen_q, seen_nxt;
  logic              acc, sop_acc, eop_acc, lost, last, reload;

  logic [1:0]        word_code;
  logic [3:0]        word_bits;
  logic [pDAT_W-1:0] ref_word, mask;
  logic [15:0]       diff;

  logic              s1_val_q, s1_sop_q, s1_eop_q, s1_lost_q, s1_last_q;
  logic [4:0]        s1_err_q;
  logic [3:0]        s1_nbits_q;

  logic [pCNT_W-1:0] bit_q, err_q;
  logic [pPKT_W-1:0] pkt_q, frm_q, lost_q;
  logic              sat_q, busy_q, done_q, pkt_err_q;

  logic [pCNT_W:0]   bit_sum, err_sum;
  logic [pPKT_W:0]   pkt_sum, frm_sum, lost_sum;
  logic              pkt_err_now, ovf;

  tcm_prbs_word #(
    .pDAT_W (pDAT_W),
    .pSEED  (pSEED)
  ) u_prbs (
    .iclk     (iclk),
    .ireset   (ireset),
    .iclkena  (iclkena),
    .ireload  (reload),
    .iadvance (acc),
    .oword    (ref_word)
  );

  always_comb begin
    st_d     = st_q;
    acc      = 1'b0;
    sop_acc  = 1'b0;
    eop_acc  = 1'b0;
    lost     = 1'b0;
    last     = 1'b0;
    reload   = 1'b0;
    seen_nxt = seen_q + pPKT_W'(1);
    if (istart) begin
      st_d = ST_WAIT_SOP;
    end else if (ival) begin
      case (st_q)
        ST_WAIT_SOP, ST_IN_PKT: begin
          if (isop || st_q == ST_IN_PKT) begin
            acc     = 1'b1;
            sop_acc = isop;
            lost    = isop && (st_q == ST_IN_PKT);
            reload  = isop;
            st_d    = ST_IN_PKT;
            if (ieop) begin
              eop_acc = 1'b1;
              last    = (npkt_q != '0) && (seen_nxt == npkt_q);
              st_d    = last ? ST_DONE : ST_WAIT_SOP;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // A start-of-packet word is compared at the code rate it carries itself
  always_comb begin
    word_code = sop_acc ? icode : code_q;
    word_bits = 4'(BASE_BITS) + {2'b00, word_code};
    mask      = '0;
    for (int unsigned i = 0; i < pDAT_W; i++) begin
      mask[i] = (i < {28'd0, word_bits});
    end
    diff = 16'((idat ^ ref_word) & mask);
  end

  always_ff @(posedge iclk) begin
    if (ireset) begin
      st_q   <= ST_IDLE;
      code_q <= '0;
      npkt_q <= '0;
      seen_q <= '0;
    end else if (iclkena) begin
      st_q <= st_d;
      if (istart) begin
        npkt_q <= inpkt;
        seen_q <= '0;
      end else if (eop_acc) begin
        seen_q <= seen_nxt;
      end
      if (sop_acc) code_q <= icode;
    end
  end

  always_ff @(posedge iclk) begin
    if (ireset) begin
      s1_val_q   <= 1'b0;
      s1_sop_q   <= 1'b0;
      s1_eop_q   <= 1'b0;
      s1_lost_q  <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_err_q   <= '0;
      s1_nbits_q <= '0;
    end else if (iclkena) begin
      s1_val_q   <= acc;
      s1_sop_q   <= sop_acc;
      s1_eop_q   <= eop_acc;
      s1_lost_q  <= lost;
      s1_last_q  <= last;
      s1_err_q   <= popcount16(diff);
      s1_nbits_q <= word_bits;
    end
  end

  always_comb begin
    bit_sum     = {1'b0, bit_q} + (pCNT_W+1)'(s1_nbits_q);
    err_sum     = {1'b0, err_q} + (pCNT_W+1)'(s1_err_q);
    pkt_sum     = {1'b0, pkt_q} + (pPKT_W+1)'(1);
    frm_sum     = {1'b0, frm_q} + (pPKT_W+1)'(1);
    lost_sum    = {1'b0, lost_q} + (pPKT_W+1)'(1);
    pkt_err_now = (s1_sop_q ? 1'b0 : pkt_err_q) | (s1_err_q != '0);
    ovf = bit_sum[pCNT_W] | err_sum[pCNT_W] | (s1_lost_q & lost_sum[pPKT_W]) |
          (s1_eop_q & (pkt_sum[pPKT_W] | (pkt_err_now & frm_sum[pPKT_W])));
  end

  always_ff @(posedge iclk) begin
    if (ireset) begin
      bit_q     <= '0;
      err_q     <= '0;
      pkt_q     <= '0;
      frm_q     <= '0;
      lost_q    <= '0;
      sat_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pkt_err_q <= 1'b0;
    end else if (iclkena) begin
      if (istart) begin
        bit_q     <= '0;
        err_q     <= '0;
        pkt_q     <= '0;
        frm_q     <= '0;
        lost_q    <= '0;
        sat_q     <= 1'b0;
        busy_q    <= 1'b1;
        done_q    <= 1'b0;
        pkt_err_q <= 1'b0;
      end else begin
        done_q <= 1'b0;
        if (s1_val_q) begin
          bit_q     <= bit_sum[pCNT_W] ? '1 : bit_sum[pCNT_W-1:0];
          err_q     <= err_sum[pCNT_W] ? '1 : err_sum[pCNT_W-1:0];
          pkt_err_q <= s1_eop_q ? 1'b0 : pkt_err_now;
          if (s1_lost_q) lost_q <= lost_sum[pPKT_W] ? '1 : lost_sum[pPKT_W-1:0];
          if (s1_eop_q) begin
            pkt_q <= pkt_sum[pPKT_W] ? '1 : pkt_sum[pPKT_W-1:0];
            if (pkt_err_now) frm_q <= frm_sum[pPKT_W] ? '1 : frm_sum[pPKT_W-1:0];
          end
          if (s1_last_q) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end
          if (ovf) sat_q <= 1'b1;
        end
      end
    end
  end

  assign obusy     = busy_q;
  assign odone     = done_q;
  assign obit_cnt  = bit_q;
  assign obiterr   = err_q;
  assign opkt_cnt  = pkt_q;
  assign ofrm_err  = frm_q;
  assign opkt_lost = lost_q;
  assign osat      = sat_q;

endmodule
